// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: bundle between the round-robin frame scheduler and its
// surroundings (requesting clients plus the 5-bit serial transmitter).
//   req/data          clients -> scheduler: level requests and 5-bit words
//   ack/done/busy     scheduler -> clients: latch strobe, frame-done, busy
//   grant_id/err      scheduler status: current/last winner, sticky error
//   tx_en/tx_baslat   scheduler -> transmitter: bit tick and start request
//   tx_D              scheduler -> transmitter: latched frame word
//   tx_mesgul         transmitter -> scheduler: busy flag
// master: the scheduler side. slave: clients + transmitter side.
interface tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   req;
  logic [5*N_REQ-1:0] data;
  logic [N_REQ-1:0]   ack;
  logic               done;
  logic               busy;
  logic [ID_W-1:0]    grant_id;
  logic               err;
  logic               tx_en;
  logic               tx_baslat;
  logic [4:0]         tx_D;
  logic               tx_mesgul;

  modport master (
    input  req, data, tx_mesgul,
    output ack, done, busy, grant_id, err, tx_en, tx_baslat, tx_D
  );

  modport slave (
    output req, data, tx_mesgul,
    input  ack, done, busy, grant_id, err, tx_en, tx_baslat, tx_D
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler sharing one 5-bit serial transmitter
// (start 0, D[0..4], stop 1; one line state per bit tick) among N_REQ
// requesters. Generates the bit tick, latches the winner's word, issues
// the start request, counts the 7 frame ticks and rotates priority.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    tx_arbiter_if.master (req/data in, ack/done/busy/grant_id/err
//          out, tx_en/tx_baslat/tx_D out, tx_mesgul in)
module tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int DIV   = 16
) (
  input  logic         clk,
  input  logic         reset,
  tx_arbiter_if.master bus
);
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;

  logic [DIV_W-1:0] div_cnt;
  logic             tx_en_q;
  logic [ID_W-1:0]  ptr;
  logic [2:0]       bitcnt;

  logic [N_REQ-1:0] ack_q;
  logic             done_q;
  logic             busy_q;
  logic [ID_W-1:0]  gid_q;
  logic [4:0]       txd_q;
  logic             err_q;
  logic             baslat;

  logic [4:0]       words [N_REQ];
  logic [ID_W-1:0]  cand;
  logic             pick_vld;
  logic [ID_W-1:0]  pick_id;
  logic [N_REQ-1:0] pick_oh;
  logic [ID_W-1:0]  ptr_nx;

  // Free-running bit-tick divider; tx_en is the registered wrap strobe,
  // so the first tick appears DIV cycles after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tx_en_q <= 1'b0;
    end else begin
      tx_en_q <= (div_cnt == DIV_W'(DIV - 1));
      div_cnt <= (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      words[i] = bus.data[5*i +: 5];
    end
  end

  // Round-robin search ptr, ptr+1, ... (mod N_REQ); first set bit wins.
  always_comb begin
    cand     = '0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % N_REQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_id  = cand;
      end
    end
  end

  always_comb begin
    pick_oh          = '0;
    pick_oh[pick_id] = 1'b1;
  end

  always_comb begin
    ptr_nx = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. A tick coinciding with the IDLE grant is not used
  // as the start tick: START always waits for a later tick.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_vld) state_nx = START;
      START:   if (tx_en_q) state_nx = SEND;
      SEND:    if (tx_en_q && bitcnt == 3'd6) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: start request is held for the whole START state, which
  // the transmitter samples on exactly one tick.
  always_comb begin
    baslat = 1'b0;
    unique case (state)
      START:   baslat = 1'b1;
      default: baslat = 1'b0;
    endcase
  end

  // Registered datapath: grant latch, tick counting, status and error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr    <= '0;
      bitcnt <= '0;
      ack_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      gid_q  <= '0;
      txd_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= 1'b0;
      // bitcnt 0..5 corresponds to transmitter states s1..s6
      if (state == SEND && bitcnt <= 3'd5 && !bus.tx_mesgul) begin
        err_q <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            txd_q  <= words[pick_id];
            gid_q  <= pick_id;
            ack_q  <= pick_oh;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (tx_en_q) bitcnt <= '0;
        end
        SEND: begin
          if (tx_en_q) begin
            if (bitcnt == 3'd6) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              ptr    <= ptr_nx;
            end else begin
              bitcnt <= bitcnt + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = gid_q;
  assign bus.err       = err_q;
  assign bus.tx_en     = tx_en_q;
  assign bus.tx_baslat = baslat;
  assign bus.tx_D      = txd_q;
endmodule

// File: tb/tb_tx_arbiter.sv
`timescale 1ns/1ps
module tb_tx_arbiter;
  localparam int N   = 4;
  localparam int DIV = 4;

  typedef struct {
    int         id;
    logic [4:0] word;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tx_arbiter_if #(.N_REQ(N)) bus ();
  tx_arbiter #(.N_REQ(N), .DIV(DIV)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  exp_t        exp_q[$];
  int unsigned target[N] = '{default: 0};
  int unsigned got[N]    = '{default: 0};
  int          bcnt[N];
  logic [4:0]  bword[N];
  int          mptr    = 0;
  logic        err_exp = 1'b0;
  logic        force_lo = 1'b0;

  // ---------------- transmitter model ----------------
  int s;
  always @(posedge clk or negedge reset) begin
    if (!reset) s <= 0;
    else if (bus.tx_en) begin
      if (s == 0) begin
        if (bus.tx_baslat) s <= 1;
      end else begin
        s <= (s == 7) ? 0 : s + 1;
      end
    end
  end
  assign bus.tx_mesgul = (s != 0) && !force_lo;

  function automatic logic ybit(input int st, input logic [4:0] d);
    if (st == 1) return 1'b0;
    else if (st >= 2 && st <= 6) return d[st-2];
    else return 1'b1;
  endfunction

  // ---------------- clients ----------------
  always_comb begin
    bus.req = '0;
    for (int i = 0; i < N; i++) bus.req[i] = (got[i] < target[i]);
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) if (bus.ack[i]) got[i]++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         cyc = 0;
  bit         frame_active = 0;
  logic [4:0] cur_word;
  int         nbas, start_cyc, nbits, prev_s, last_tick;
  bit         tick_valid = 0;
  logic [6:0] bits;
  exp_t       me;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      frame_active = 0;
      tick_valid   = 0;
      nbits        = 0;
      prev_s       = 0;
    end else begin
      if (bus.tx_en) begin
        if (tick_valid) chk("tick_gap", 64'(cyc - last_tick), 64'(DIV));
        last_tick  = cyc;
        tick_valid = 1;
      end
      if (s != prev_s && s != 0 && nbits < 7) begin
        bits[nbits] = ybit(s, bus.tx_D);
        nbits++;
      end
      prev_s = s;
      if (frame_active && bus.tx_en && bus.tx_baslat) begin
        if (nbas == 0) start_cyc = cyc;
        nbas++;
      end
      if (bus.ack != '0) begin
        chk("ack_overlap", 64'(frame_active), 64'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got %0b expected none", bus.ack);
        end else begin
          me = exp_q.pop_front();
          chk("ack_onehot", 64'(bus.ack), 64'(1) << me.id);
          chk("grant_id", 64'(bus.grant_id), 64'(me.id));
          chk("tx_D_latch", 64'(bus.tx_D), 64'(me.word));
          chk("busy_at_ack", 64'(bus.busy), 64'd1);
          frame_active = 1;
          cur_word     = me.word;
          nbas         = 0;
          nbits        = 0;
        end
      end
      if (bus.done) begin
        if (!frame_active) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          chk("baslat_ticks", 64'(nbas), 64'd1);
          // start tick is seen on the negedge before its active edge
          chk("frame_len", 64'(cyc - start_cyc), 64'(7*DIV + 1));
          chk("frame_nbits", 64'(nbits), 64'd7);
          chk("frame_bits", 64'(bits), 64'({1'b1, cur_word, 1'b0}));
          chk("busy_at_done", 64'(bus.busy), 64'd0);
          chk("tx_D_stable", 64'(bus.tx_D), 64'(cur_word));
          chk("err_at_done", 64'(bus.err), 64'(err_exp));
          frame_active = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_b(input int c0, c1, c2, c3,
                       input logic [4:0] w0, w1, w2, w3);
    bcnt[0] = c0; bcnt[1] = c1; bcnt[2] = c2; bcnt[3] = c3;
    bword[0] = w0; bword[1] = w1; bword[2] = w2; bword[3] = w3;
  endtask

  // Expected grants: each pending request served once per visit, scanning
  // from the rotating pointer; pointer moves past each winner.
  task automatic issue();
    int rem[N];
    int p;
    bit any;
    exp_t e;
    for (int i = 0; i < N; i++) begin
      rem[i] = bcnt[i];
      if (bcnt[i] > 0) bus.data[5*i +: 5] = bword[i];
    end
    p = mptr;
    do begin
      any = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (p + k) % N;
        if (rem[j] > 0) begin
          e.id = j;
          e.word = bword[j];
          exp_q.push_back(e);
          rem[j]--;
          p = (j + 1) % N;
          any = 1;
          break;
        end
      end
    end while (any);
    mptr = p;
    for (int i = 0; i < N; i++) target[i] += bcnt[i];
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || frame_active) && n < limit);
    if (n >= limit) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_state(input int st, input int limit);
    int n;
    n = 0;
    while (s != st && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      total++;
      bad++;
      $display("FAIL state_timeout: got s=%0d expected s=%0d", s, st);
    end
  endtask

  task automatic do_reset();
    int k;
    reset = 1'b0;
    for (int i = 0; i < N; i++) target[i] = got[i];
    exp_q.delete();
    mptr     = 0;
    err_exp  = 1'b0;
    force_lo = 1'b0;
    #1;
    chk("reset_outs", 64'({bus.ack, bus.done, bus.busy, bus.grant_id, bus.err,
                           bus.tx_en, bus.tx_baslat, bus.tx_D}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.tx_en && k < 4*DIV);
    chk("first_tick", 64'(k), 64'(DIV));
  endtask

  initial begin
    int n;
    bus.data = '0;
    @(negedge clk);
    do_reset();

    // all four held; requester 0 asks twice -> 0,1,2,3,0
    set_b(2, 1, 1, 1, 5'h03, 5'h0C, 5'h15, 5'h1A);
    issue();
    wait_idle(1500);

    // single frame with word 10110 (line 0,0,1,1,0,1,1)
    set_b(1, 0, 0, 0, 5'b10110, 5'h00, 5'h00, 5'h00);
    issue();
    wait_idle(500);

    // grant 1 leaves pointer at 2; 0011 then wraps to 0; then 1010
    set_b(0, 1, 0, 0, 5'h00, 5'h09, 5'h00, 5'h00);
    issue();
    wait_idle(500);
    set_b(1, 1, 0, 0, 5'h1E, 5'h04, 5'h00, 5'h00);
    mptr = mptr;
    issue();
    wait_idle(1000);
    set_b(0, 1, 0, 1, 5'h00, 5'h17, 5'h00, 5'h08);
    issue();
    wait_idle(1000);

    // transmitter busy flag forced low at bitcnt=2 (transmitter s3)
    set_b(0, 0, 1, 0, 5'h00, 5'h00, 5'h13, 5'h00);
    issue();
    wait_state(3, 300);
    force_lo = 1'b1;
    err_exp  = 1'b1;
    @(negedge clk);
    force_lo = 1'b0;
    chk("err_set", 64'(bus.err), 64'd1);
    wait_idle(500);

    // request raised in the done cycle is granted on the next cycle
    set_b(0, 0, 0, 1, 5'h00, 5'h00, 5'h00, 5'h0B);
    issue();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 500);
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done");
    end
    set_b(0, 1, 0, 0, 5'h00, 5'h1C, 5'h00, 5'h00);
    issue();
    @(negedge clk);
    chk("ack_after_done", 64'(bus.ack), 64'b0010);
    wait_idle(500);

    // randomized batches
    for (int b = 0; b < 18; b++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        bcnt[i]  = m[i] ? int'($urandom_range(1, 2)) : 0;
        bword[i] = 5'($urandom);
      end
      issue();
      wait_idle(2000);
    end

    // reset mid-frame at bitcnt=3 (transmitter s4), then fresh arbitration
    set_b(0, 1, 0, 0, 5'h00, 5'h11, 5'h00, 5'h00);
    issue();
    wait_state(4, 300);
    @(negedge clk);
    do_reset();
    set_b(0, 0, 1, 0, 5'h00, 5'h00, 5'h0E, 5'h00);
    issue();
    wait_idle(500);

    for (int b = 0; b < 6; b++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        bcnt[i]  = m[i] ? 1 : 0;
        bword[i] = 5'($urandom);
      end
      issue();
      wait_idle(1500);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
